// File: rtl/jtag_ir_ctrl_pkg.sv
// Shared constants for the JTAG instruction-register controller: default
// widths, well-known opcodes, default opcode table and the capture LSBs.
package jtag_ir_ctrl_pkg;

  // Default DR slots in the stock four-register configuration.
  typedef enum int unsigned {
    DR_BYPASS = 0,
    DR_IDCODE = 1,
    DR_USER0  = 2,
    DR_USER1  = 3
  } dr_idx_e;

  localparam int IR_W_DEF     = 4;
  localparam int NUM_DR_DEF   = 4;
  localparam int RESET_DR_DEF = int'(DR_IDCODE);

  localparam logic [IR_W_DEF-1:0] BYPASS_OP = '1;
  localparam logic [IR_W_DEF-1:0] IDCODE_OP = 4'h1;

  // Entry k is the opcode selecting DR k; entry 0 is BYPASS (all ones).
  localparam logic [NUM_DR_DEF-1:0][IR_W_DEF-1:0] DR_OPCODES_DEF =
    {4'h3, 4'h2, IDCODE_OP, BYPASS_OP};

  // Fixed low bits loaded by Capture-IR.
  localparam logic [1:0] CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/jtag_ir_decode.sv
// Combinational opcode lookup: one-hot DR select plus a hit flag. The first
// (lowest-index) matching entry wins; a miss selects BYPASS (bit 0).
module jtag_ir_decode #(
  parameter int IR_W   = 4,
  parameter int NUM_DR = 4,
  parameter logic [NUM_DR-1:0][IR_W-1:0] DR_OPCODES = '1
) (
  input  logic [IR_W-1:0]   i_opcode,
  output logic [NUM_DR-1:0] o_sel,
  output logic              o_hit
);

  // Scan the table, keep only the first match, fall back to BYPASS on a miss.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path can hold an old value and infer a latch.
    o_sel = '0;
    o_hit = 1'b0;
    for (int k = 0; k < NUM_DR; k++) begin
      if (!o_hit && (i_opcode == DR_OPCODES[k])) begin
        o_sel[k] = 1'b1;
        o_hit    = 1'b1;
      end
    end
    if (!o_hit) begin
      o_sel[0] = 1'b1;
    end
  end

endmodule

// File: rtl/jtag_ir_ctrl.sv
// JTAG instruction-register controller: IR shift chain (Capture/Shift/Update),
// active instruction, registered one-hot DR select and a sticky invalid flag.
module jtag_ir_ctrl
  import jtag_ir_ctrl_pkg::*;
#(
  parameter int IR_W     = IR_W_DEF,
  parameter int NUM_DR   = NUM_DR_DEF,
  parameter logic [NUM_DR-1:0][IR_W-1:0] DR_OPCODES = DR_OPCODES_DEF,
  parameter int RESET_DR = RESET_DR_DEF
) (
  input  logic              i_tclk,
  input  logic              i_trst,
  input  logic              i_tdi,
  input  logic              i_stateIsTestLogicReset,
  input  logic              i_stateIsCaptureIr,
  input  logic              i_stateIsShiftIr,
  input  logic              i_stateIsUpdateIr,
  output logic              o_irTdo,
  output logic [IR_W-1:0]   o_instrReg,
  output logic [NUM_DR-1:0] o_drSel,
  output logic              o_instrUpdated,
  output logic              o_instrInvalid
);

  localparam logic [IR_W-1:0]   RESET_INSTR   = DR_OPCODES[RESET_DR];
  localparam logic [NUM_DR-1:0] RESET_SEL     = {{(NUM_DR-1){1'b0}}, 1'b1} << RESET_DR;
  localparam logic [IR_W-1:0]   RESET_CAPTURE = {{(IR_W-2){1'b0}}, CAPTURE_LSBS};

  logic [IR_W-1:0]   shift_q;
  logic [IR_W-1:0]   capture_pat;
  logic [NUM_DR-1:0] dec_sel;
  logic              dec_hit;

  // Capture pattern: fixed 01 in the LSBs, the sticky flag above them, zeros on top.
  always_comb begin
    capture_pat      = '0;
    capture_pat[1:0] = CAPTURE_LSBS;
    capture_pat[2]   = o_instrInvalid;
  end

  jtag_ir_decode #(
    .IR_W       (IR_W),
    .NUM_DR     (NUM_DR),
    .DR_OPCODES (DR_OPCODES)
  ) u_decode (
    .i_opcode (shift_q),
    .o_sel    (dec_sel),
    .o_hit    (dec_hit)
  );

  assign o_irTdo = shift_q[0];

  // TAP-state driven IR update; TLR > Update > Capture > Shift > hold.
  always_ff @(posedge i_tclk or posedge i_trst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_trst) begin
      shift_q        <= RESET_CAPTURE;
      o_instrReg     <= RESET_INSTR;
      o_drSel        <= RESET_SEL;
      o_instrUpdated <= 1'b0;
      o_instrInvalid <= 1'b0;
    end else if (i_stateIsTestLogicReset) begin
      shift_q        <= RESET_CAPTURE;
      o_instrReg     <= RESET_INSTR;
      o_drSel        <= RESET_SEL;
      o_instrUpdated <= 1'b0;
      o_instrInvalid <= 1'b0;
    end else begin
      o_instrUpdated <= 1'b0;
      if (i_stateIsUpdateIr) begin
        o_instrReg     <= shift_q;
        o_drSel        <= dec_sel;
        o_instrUpdated <= 1'b1;
        if (!dec_hit) begin
          o_instrInvalid <= 1'b1;
        end
      end else if (i_stateIsCaptureIr) begin
        shift_q        <= capture_pat;
        o_instrInvalid <= 1'b0;
      end else if (i_stateIsShiftIr) begin
        shift_q <= {i_tdi, shift_q[IR_W-1:1]};
      end
    end
  end

endmodule
